// File: rtl/program_sequencer.sv
// program_sequencer: program RAM and PC that feed words to the processor bus on Ext/IRin requests.
// Runs to end of program or single-steps per instruction; issues NOP_WORD whenever it has nothing to give.
module program_sequencer #(
    parameter int          ADDR_W   = 4,
    parameter logic [9:0]  NOP_WORD = 10'h002
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [9:0]        prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              Ext,
    input  logic              IRin,
    input  logic              Clr,
    output logic [9:0]        data,
    output logic [ADDR_W:0]   pc,
    output logic              running,
    output logic              halted,
    output logic [7:0]        fetch_count
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d, len_q, len_d;
    logic [7:0]        fetch_count_q, fetch_count_d;
    logic              running_q, halted_q;
    logic              idle_or_halt, issue;
    logic [9:0]        mem [DEPTH];

    always_comb begin
        idle_or_halt  = state_q == IDLE || state_q == HALT;
        issue         = state_q == RUN && pc_q < len_q;
        state_d       = state_q;
        pc_d          = pc_q;
        len_d         = len_q;
        fetch_count_d = fetch_count_q;
        if (idle_or_halt && start) begin
            pc_d          = '0;
            fetch_count_d = '0;
            // lengths beyond the RAM are clamped so pc can never index past it
            len_d         = prog_len > DEPTH_W ? DEPTH_W : prog_len;
            state_d       = prog_len == '0 ? HALT : RUN;
        end else if (state_q == RUN) begin
            if (issue && Ext) begin
                pc_d = pc_q + 1'b1;
                if (IRin && fetch_count_q != 8'hFF)
                    fetch_count_d = fetch_count_q + 8'd1;
            end
            if (Ext && !issue)
                state_d = HALT;
            else if (Clr && step_mode)
                state_d = PAUSE;
        end else if (state_q == PAUSE && (step || !step_mode)) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            fetch_count_q <= '0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            fetch_count_q <= fetch_count_d;
            running_q     <= state_d == RUN;
            halted_q      <= state_d == HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && idle_or_halt)
            mem[prog_addr] <= prog_data;
    end

    assign data        = issue ? mem[pc_q[ADDR_W-1:0]] : NOP_WORD;
    assign pc          = pc_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed steps with a queue of expected values checked by immediate assertions.
module tb_program_sequencer;
    localparam int AW = 9;

    logic          clk = 1'b0, reset = 1'b1;
    logic          prog_we = 1'b0, start = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic          ext = 1'b0, irin = 1'b0, clr = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [9:0]    prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic [9:0]    data;
    logic [AW:0]   pc;
    logic          running, halted;
    logic [7:0]    fetch_count;

    int            errors = 0, checks = 0;
    logic [31:0]   exp_q [$];

    program_sequencer #(.ADDR_W(AW), .NOP_WORD(10'h002)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start),
        .step_mode(step_mode), .step(step), .Ext(ext), .IRin(irin), .Clr(clr),
        .data(data), .pc(pc), .running(running), .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = 32'hDEAD_BEEF;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    task automatic wr(input int a, input logic [9:0] d);
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic go(input int len);
        prog_len = (AW + 1)'(len); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        push(0); check("rst_pc", pc);
        push(0); check("rst_fetch", fetch_count);
        push(0); check("rst_running", running);
        push(0); check("rst_halted", halted);
        push(10'h002); check("rst_data", data);

        // basic fetch
        wr(0, 10'h101); wr(1, 10'h2A5);
        go(2);
        push(1); check("t1_running", running);
        ext = 1; irin = 1; #1;
        push(10'h101); check("t1_data", data);
        tick();
        push(1); check("t1_pc", pc);
        push(1); check("t1_fetch", fetch_count);
        irin = 0; #1;
        push(10'h2A5); check("t1_operand", data);
        tick();
        push(2); check("t1_pc2", pc);
        // end of program on a fetch
        irin = 1; #1;
        push(10'h002); check("t3_nop", data);
        tick();
        ext = 0; irin = 0;
        push(1); check("t3_halted", halted);
        push(2); check("t3_pc", pc);
        push(1); check("t3_fetch", fetch_count);

        // LOAD flow then missing operand halts
        wr(0, 10'h0C0); wr(1, 10'h3FF);
        go(2);
        ext = 1; irin = 1; #1;
        push(10'h0C0); check("t2_instr", data);
        tick();
        irin = 0; #1;
        push(10'h3FF); check("t2_operand", data);
        tick();
        push(2); check("t2_pc", pc);
        push(1); check("t2_fetch", fetch_count);
        tick();
        ext = 0;
        push(1); check("t2_halt_load", halted);
        push(0); check("t2_not_running", running);

        // single step
        wr(0, 10'h111); wr(1, 10'h222); wr(2, 10'h333);
        step_mode = 1;
        go(3);
        ext = 1; irin = 1; clr = 1; #1;
        push(10'h111); check("t4_data0", data);
        tick();
        clr = 0;
        push(0); check("t4_paused", running);
        push(1); check("t4_pc", pc);
        #1;
        push(10'h002); check("t4_pause_nop", data);
        tick();
        push(1); check("t4_pc_frozen", pc);
        push(1); check("t4_fetch_frozen", fetch_count);
        ext = 0; irin = 0; step = 1;
        tick();
        step = 0;
        push(1); check("t4_step_run", running);
        ext = 1; irin = 1; clr = 1; #1;
        push(10'h222); check("t4_data1", data);
        tick();
        ext = 0; irin = 0; clr = 0;
        push(0); check("t4_paused2", running);
        step_mode = 0;
        tick();
        push(1); check("t4_mode_off_run", running);

        // write ignored in RUN; reset mid-run
        wr(0, 10'h155);
        ext = 1; irin = 1; #1;
        push(10'h333); check("t5_data2", data);
        tick();
        ext = 0; irin = 0;
        push(3); check("t5_pc3", pc);
        reset = 1;
        tick();
        reset = 0;
        push(0); check("t5_rst_pc", pc);
        push(0); check("t5_rst_fetch", fetch_count);
        push(0); check("t5_rst_running", running);
        go(3);
        #1;
        push(10'h111); check("t5_ram_intact", data);

        // zero-length program
        reset = 1; tick(); reset = 0;
        go(0);
        push(1); check("t6_len0_halt", halted);
        push(0); check("t6_len0_run", running);

        // start with same-cycle write
        prog_we = 1; prog_addr = '0; prog_data = 10'h3C3;
        go(1);
        prog_we = 0; #1;
        push(10'h3C3); check("t6_write_start", data);

        // fetch counter saturation
        reset = 1; tick(); reset = 0;
        go(300);
        ext = 1; irin = 1;
        for (int i = 0; i < 255; i++) tick();
        push(8'hFF); check("t6_fetch_255", fetch_count);
        push(255); check("t6_pc_255", pc);
        for (int i = 0; i < 45; i++) tick();
        push(8'hFF); check("t6_fetch_sat", fetch_count);
        push(300); check("t6_pc_300", pc);
        push(1); check("t6_running", running);
        tick();
        ext = 0; irin = 0;
        push(1); check("t6_end_halt", halted);
        push(300); check("t6_end_pc", pc);
        push(8'hFF); check("t6_end_fetch", fetch_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
